// File: rtl/load_store_unit.sv
// Load/store bridge from the CPU datapath to a word-wide RAM bus with byte enables.
// Optional MISALIGN_TRAP_EN: misaligned half/word requests fail without a bus cycle.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [2:0]  resp_size,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q;
  logic [2:0]  size_q;
  logic        we_q;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  rsize_q, rsize_d;
  logic        err_q, err_d;

  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wrep, lmask, load_c;

  function automatic logic bad_size(input logic we, input logic [2:0] sz);
    case (sz)
      3'b000, 3'b001, 3'b010: bad_size = 1'b0;
      3'b100, 3'b101:         bad_size = we;
      default:                bad_size = 1'b1;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] sz, input logic [1:0] a);
    case (sz[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = |a;
      default: misaligned = 1'b0;
    endcase
  endfunction

  // Lane steering from the captured request; misaligned offsets are truncated.
  always_comb begin
    off   = 2'd0;
    be_c  = 4'b1111;
    wrep  = wdata_q;
    lmask = 32'hFFFF_FFFF;
    case (size_q[1:0])
      2'b00: begin
        off   = addr_q[1:0];
        be_c  = 4'b0001 << off;
        wrep  = {4{wdata_q[7:0]}};
        lmask = 32'h0000_00FF;
      end
      2'b01: begin
        off   = {addr_q[1], 1'b0};
        be_c  = 4'b0011 << off;
        wrep  = {2{wdata_q[15:0]}};
        lmask = 32'h0000_FFFF;
      end
      default: ;
    endcase
    load_c = (mem_rdata >> {off, 3'b000}) & lmask;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    rsize_d = rsize_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (req_valid) begin
        if (bad_size(req_we, req_size) || (TRAP && misaligned(req_size, req_addr[1:0]))) begin
          state_d = RESP;
          rdata_d = 32'd0;
          rsize_d = req_size;
          err_d   = 1'b1;
        end else begin
          state_d = BUS;
          cnt_d   = 32'd0;
        end
      end
      BUS: begin
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          state_d = RESP;
          rdata_d = we_q ? 32'd0 : load_c;
          rsize_d = size_q;
          err_d   = 1'b0;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d = RESP;
          rdata_d = 32'd0;
          rsize_d = size_q;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 32'd0;
      rdata_q <= 32'd0;
      rsize_q <= 3'd0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      size_q  <= 3'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      rsize_q <= rsize_d;
      err_q   <= err_d;
      if (state_q == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        size_q  <= req_size;
        we_q    <= req_we;
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_size  = rsize_q;
  assign resp_err   = err_q;
  assign mem_req    = (state_q == BUS);
  assign mem_we     = mem_req & we_q;
  assign mem_be     = mem_req ? be_c : 4'd0;
  assign mem_addr   = mem_req ? {addr_q[31:2], 2'b00} : 32'd0;
  assign mem_wdata  = (mem_req && we_q) ? wrep : 32'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-cycle comparison against a transaction-level
// model, plus literal checks on the documented example transactions.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [2:0]  req_size = 3'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [2:0]  resp_size;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_size(resp_size),
    .resp_err(resp_err), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_en = 1'b0;

  // Expected per-cycle outputs; resp_* values persist until the next response.
  logic        e_ready = 1'b1, e_mreq = 1'b0, e_we = 1'b0, e_rvalid = 1'b0, e_rerr = 1'b0;
  logic [3:0]  e_be = 4'd0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0, e_rdata = 32'd0;
  logic [2:0]  e_rsize = 3'd0;

  // Observations taken by the compare process for literal checks.
  logic [31:0] o_addr = 0, o_wdata = 0, o_rdata = 0;
  logic [3:0]  o_be = 0;
  logic        o_we = 0, o_err = 0;
  logic [2:0]  o_size = 0;
  int          o_nreq = 0, o_nresp = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("req_ready",  32'(req_ready),  32'(e_ready));
    chk("mem_req",    32'(mem_req),    32'(e_mreq));
    chk("mem_we",     32'(mem_we),     32'(e_we));
    chk("mem_be",     32'(mem_be),     32'(e_be));
    chk("mem_addr",   mem_addr,        e_addr);
    if (!e_mreq || e_we) chk("mem_wdata", mem_wdata, e_wdata);
    chk("resp_valid", 32'(resp_valid), 32'(e_rvalid));
    chk("resp_rdata", resp_rdata,      e_rdata);
    chk("resp_size",  32'(resp_size),  32'(e_rsize));
    chk("resp_err",   32'(resp_err),   32'(e_rerr));
    if (mem_req) begin
      o_addr = mem_addr; o_be = mem_be; o_we = mem_we; o_wdata = mem_wdata; o_nreq++;
    end
    if (resp_valid) begin
      o_rdata = resp_rdata; o_err = resp_err; o_size = resp_size; o_nresp++;
    end
  end

  // Transaction-level model from the lane rules, using plain arithmetic.
  task automatic model(input logic we, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd,
                       output bit bad, output bit trap, output logic [3:0] be,
                       output logic [31:0] bwd, output logic [31:0] ld);
    int nb, off;
    longint mask;
    bad = !(sz == 0 || sz == 1 || sz == 2 || ((sz == 4 || sz == 5) && !we));
    nb  = bad ? 1 : (1 << sz[1:0]);
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = !bad && (a % nb != 0);
`endif
    off  = ((a % 4) / nb) * nb;
    be   = 4'(((1 << nb) - 1) << off);
    bwd  = (nb == 1) ? wd[7:0] * 32'h0101_0101 : (nb == 2) ? wd[15:0] * 32'h0001_0001 : wd;
    mask = (64'd1 << (8 * nb)) - 1;
    ld   = 32'((64'(rd) >> (8 * off)) & mask);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic exp_idle;
    e_ready = 1; e_mreq = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0; e_rvalid = 0;
  endtask

  // ackd = BUS cycles without ack before the ack cycle; ackd >= TO means timeout.
  task automatic txn(input logic we, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input int ackd, input logic [31:0] rd);
    bit bad, trap, tmo;
    logic [3:0] be;
    logic [31:0] bwd, ld;
    model(we, sz, a, wd, rd, bad, trap, be, bwd, ld);
    tick;
    req_valid = 1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    exp_idle;
    tmo = 0;
    if (!bad && !trap) begin
      for (int k = 0; k < TO; k++) begin
        tick;
        req_addr = ~a; req_wdata = ~wd; req_we = ~we;
        mem_ack = (k == ackd);
        mem_rdata = mem_ack ? rd : 32'hDEAD_BEEF;
        e_ready = 0; e_mreq = 1; e_we = we; e_be = be; e_addr = a & 32'hFFFF_FFFC;
        e_wdata = bwd;
        if (k == ackd) break;
        if (k == TO - 1) tmo = 1;
      end
    end
    tick;
    req_valid = 0; mem_ack = 1; mem_rdata = 32'h1234_5678;
    exp_idle;
    e_ready = 0; e_rvalid = 1; e_rsize = sz;
    e_rerr = bad || trap || tmo;
    e_rdata = (bad || trap || tmo || we) ? 32'd0 : ld;
    tick;
    mem_ack = 0;
    exp_idle;
  endtask

  initial begin
    int n0, r0;
    #1 rst_n = 0;
    chk_en = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // lb 0x103, ack on second BUS cycle.
    n0 = o_nreq;
    txn(0, 3'b000, 32'h103, 32'h0, 1, 32'h80FF_1234);
    chk("lb_addr", o_addr, 32'h100);
    chk("lb_be", 32'(o_be), 32'h8);
    chk("lb_rdata", o_rdata, 32'h80);
    chk("lb_size", 32'(o_size), 32'h0);
    chk("lb_nreq", 32'(o_nreq - n0), 32'd2);

    // sh 0x22.
    txn(1, 3'b001, 32'h22, 32'h0000_ABCD, 0, 32'h0);
    chk("sh_we", 32'(o_we), 32'h1);
    chk("sh_addr", o_addr, 32'h20);
    chk("sh_be", 32'(o_be), 32'hC);
    chk("sh_wdata", o_wdata, 32'hABCD_ABCD);
    chk("sh_err", 32'(o_err), 32'h0);

    // lw 0x40 with no ack: times out after TO bus cycles.
    n0 = o_nreq;
    txn(0, 3'b010, 32'h40, 32'h0, 99, 32'h0);
    chk("to_nreq", 32'(o_nreq - n0), 32'd4);
    chk("to_err", 32'(o_err), 32'h1);
    chk("to_rdata", o_rdata, 32'h0);

    // lw 0x101 misaligned.
    n0 = o_nreq;
    txn(0, 3'b010, 32'h101, 32'h0, 0, 32'h1122_3344);
`ifdef MISALIGN_TRAP_EN
    chk("mis_nreq", 32'(o_nreq - n0), 32'd0);
    chk("mis_err", 32'(o_err), 32'h1);
`else
    chk("mis_addr", o_addr, 32'h100);
    chk("mis_be", 32'(o_be), 32'hF);
    chk("mis_err", 32'(o_err), 32'h0);
    chk("mis_rdata", o_rdata, 32'h1122_3344);
`endif

    // Bad size codes never reach the bus.
    n0 = o_nreq;
    txn(0, 3'b011, 32'h10, 32'h0, 0, 32'h0);
    txn(0, 3'b110, 32'h10, 32'h0, 0, 32'h0);
    txn(1, 3'b111, 32'h10, 32'h0, 0, 32'h0);
    txn(1, 3'b100, 32'h10, 32'h0, 0, 32'h0);
    chk("bad_nreq", 32'(o_nreq - n0), 32'd0);
    chk("bad_err", 32'(o_err), 32'h1);

    // Assorted lanes, including ack on the last cycle before timeout.
    txn(0, 3'b100, 32'h102, 32'h0, 0, 32'h11AA_2233);
    chk("lbu_rdata", o_rdata, 32'hAA);
    txn(0, 3'b101, 32'h106, 32'h0, 2, 32'hA1B2_C3D4);
    chk("lhu_rdata", o_rdata, 32'hA1B2);
    txn(0, 3'b001, 32'h200, 32'h0, 3, 32'hCAFE_F00D);
    chk("lh_late_err", 32'(o_err), 32'h0);
    txn(1, 3'b000, 32'h301, 32'h0000_005A, 0, 32'h0);
    chk("sb_wdata", o_wdata, 32'h5A5A_5A5A);
    txn(1, 3'b010, 32'h400, 32'h1234_5678, 1, 32'h0);
    txn(0, 3'b000, 32'h7FF, 32'h0, 0, 32'h8899_AABB);

    // Reset while a load is on the bus.
    tick;
    req_valid = 1; req_we = 0; req_size = 3'b010; req_addr = 32'h200;
    exp_idle;
    tick;
    req_valid = 0;
    e_ready = 0; e_mreq = 1; e_be = 4'hF; e_addr = 32'h200;
    tick;
    rst_n = 0;
    exp_idle;
    e_rdata = 0; e_rsize = 0; e_rerr = 0;
    #1 chk("rst_mreq_now", 32'(mem_req), 32'h0);
    r0 = o_nresp;
    tick;
    rst_n = 1; mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick;
    tick;
    mem_ack = 0;
    tick;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_noresp", 32'(o_nresp - r0), 32'd0);

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
